// File: rtl/riscv_mtimer_pkg.sv
// Shared register map, control bit positions and address decode for the
// riscv_mtimer peripheral. Software tests and the bench use the same constants.
package riscv_mtimer_pkg;

  localparam int MT_ADDR_CTRL    = 'h00;
  localparam int MT_ADDR_PSC     = 'h04;
  localparam int MT_ADDR_CNT_LO  = 'h08;
  localparam int MT_ADDR_CNT_HI  = 'h0C;
  localparam int MT_ADDR_STATUS  = 'h10;
  localparam int MT_ADDR_CH_BASE = 'h20;
  localparam int MT_CH_STRIDE    = 8;

  localparam int MT_CTRL_EN_BIT     = 0;
  localparam int MT_CTRL_RELOAD_BIT = 1;
  localparam int MT_CHCTRL_IE_BIT   = 0;

  typedef enum logic [2:0] {
    MT_REG_NONE,
    MT_REG_CTRL,
    MT_REG_PSC,
    MT_REG_CNT_LO,
    MT_REG_CNT_HI,
    MT_REG_STATUS,
    MT_REG_CMP,
    MT_REG_CHCTRL
  } mt_reg_e;

  typedef struct packed {
    mt_reg_e    sel;
    logic [2:0] ch;
  } mt_dec_t;

  // Byte address to register select; the two low address bits are ignored.
  function automatic mt_dec_t mt_decode(input logic [7:0] addr, input int n_ch);
    mt_dec_t d;
    int      off;
    d.sel = MT_REG_NONE;
    d.ch  = '0;
    off   = int'({addr[7:2], 2'b00});
    case (off)
      MT_ADDR_CTRL:   d.sel = MT_REG_CTRL;
      MT_ADDR_PSC:    d.sel = MT_REG_PSC;
      MT_ADDR_CNT_LO: d.sel = MT_REG_CNT_LO;
      MT_ADDR_CNT_HI: d.sel = MT_REG_CNT_HI;
      MT_ADDR_STATUS: d.sel = MT_REG_STATUS;
      default: begin
        if (off >= MT_ADDR_CH_BASE && off < MT_ADDR_CH_BASE + MT_CH_STRIDE * n_ch) begin
          d.ch  = 3'((off - MT_ADDR_CH_BASE) / MT_CH_STRIDE);
          d.sel = off[2] ? MT_REG_CHCTRL : MT_REG_CMP;
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/riscv_mtimer_ch.sv
// One compare channel: holds CMP, interrupt enable and the pending flag, and
// reports the raw match plus the enabled pending bit to the top level.
module riscv_mtimer_ch
  import riscv_mtimer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_tick,
  input  logic             i_cmp_we,
  input  logic             i_ie_we,
  input  logic             i_clr,
  input  logic [31:0]      i_wdata,
  output logic             o_match,
  output logic             o_pend_ie,
  output logic             o_pending,
  output logic             o_ie,
  output logic [31:0]      o_cmp_lo
);

  logic [CNT_W-1:0] r_cmp;
  logic             r_ie;
  logic             r_pending;
  logic [CNT_W-1:0] w_cmp_wr;

  // Software only reaches the low 32 bits of CMP; wider compares keep their upper bits.
  if (CNT_W > 32) begin : g_wide
    always_comb begin
      w_cmp_wr        = r_cmp;
      w_cmp_wr[31:0]  = i_wdata;
    end
    assign o_cmp_lo = r_cmp[31:0];
  end else begin : g_narrow
    assign w_cmp_wr = i_wdata[CNT_W-1:0];
    assign o_cmp_lo = 32'(r_cmp);
  end

  assign o_match   = (i_count == r_cmp);
  assign o_pend_ie = r_pending & r_ie;
  assign o_pending = r_pending;
  assign o_ie      = r_ie;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp     <= '1;
      r_ie      <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (i_cmp_we) r_cmp <= w_cmp_wr;
      if (i_ie_we)  r_ie  <= i_wdata[MT_CHCTRL_IE_BIT];
      // A new match beats a simultaneous write-1-to-clear.
      if (i_tick && o_match) r_pending <= 1'b1;
      else if (i_clr)        r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_mtimer.sv
// Multi-channel compare timer with single-cycle bus and level interrupt.
// Define MTIMER_PSC_EN to build the prescaler; otherwise every enabled cycle ticks.
module riscv_mtimer
  import riscv_mtimer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int N_CH  = 2,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        timer_irq_o
);

  logic             r_en;
  logic             r_reload;
  logic [CNT_W-1:0] r_count;
  logic             r_ack;
  logic [31:0]      r_rdata;
  logic             r_irq;

  mt_dec_t          w_dec;
  logic             w_wr;
  logic             w_tick;
  logic             w_cnt_lo_wr;
  logic             w_cnt_hi_wr;
  logic [CNT_W-1:0] w_count_wr;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_cnt_lo_rd;
  logic [31:0]      w_cnt_hi_rd;
  logic [31:0]      w_psc_rd;
  logic [31:0]      w_rd;
  logic [N_CH-1:0]  w_match;
  logic [N_CH-1:0]  w_pend_ie;
  logic [N_CH-1:0]  w_pending;
  logic [N_CH-1:0]  w_ie;
  logic [N_CH-1:0]  w_cmp_we;
  logic [N_CH-1:0]  w_ie_we;
  logic [N_CH-1:0]  w_clr;
  logic [31:0]      w_cmp_lo [N_CH];
  logic             w_unused;

  assign w_dec       = mt_decode(addr_i, N_CH);
  assign w_wr        = req_i && we_i;
  assign w_cnt_lo_wr = w_wr && (w_dec.sel == MT_REG_CNT_LO);
  assign w_cnt_hi_wr = w_wr && (w_dec.sel == MT_REG_CNT_HI) && (CNT_W > 32);
  assign w_unused    = ^{addr_i[1:0], w_match};

`ifdef MTIMER_PSC_EN
  logic [PSC_W-1:0] r_psc;
  logic [PSC_W-1:0] r_psc_cnt;

  assign w_tick   = r_en && (r_psc_cnt == r_psc);
  assign w_psc_rd = 32'(r_psc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc     <= '0;
      r_psc_cnt <= '0;
    end else if (w_wr && (w_dec.sel == MT_REG_PSC)) begin
      r_psc     <= wdata_i[PSC_W-1:0];
      r_psc_cnt <= '0;
    end else if (w_tick) begin
      r_psc_cnt <= '0;
    end else if (r_en) begin
      r_psc_cnt <= r_psc_cnt + PSC_W'(1);
    end
  end
`else
  assign w_tick   = r_en;
  assign w_psc_rd = '0;
`endif

  // COUNT is split into two 32-bit software windows; the high one exists only for wide counters.
  if (CNT_W > 32) begin : g_cnt_wide
    always_comb begin
      w_count_wr = r_count;
      if (w_cnt_lo_wr) w_count_wr[31:0]      = wdata_i;
      if (w_cnt_hi_wr) w_count_wr[CNT_W-1:32] = wdata_i[CNT_W-33:0];
    end
    assign w_cnt_lo_rd = r_count[31:0];
    assign w_cnt_hi_rd = 32'(r_count[CNT_W-1:32]);
  end else begin : g_cnt_narrow
    assign w_count_wr  = wdata_i[CNT_W-1:0];
    assign w_cnt_lo_rd = 32'(r_count);
    assign w_cnt_hi_rd = '0;
  end

  // A software write discards the tick's increment; matches still see the old COUNT.
  always_comb begin
    w_count_nxt = r_count;
    if (w_cnt_lo_wr || w_cnt_hi_wr)  w_count_nxt = w_count_wr;
    else if (w_tick && r_reload && w_match[0]) w_count_nxt = '0;
    else if (w_tick)                 w_count_nxt = r_count + CNT_W'(1);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cmp_we = '0;
    w_ie_we  = '0;
    w_clr    = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_cmp_we[i] = w_wr && (w_dec.sel == MT_REG_CMP)    && (w_dec.ch == 3'(i));
      w_ie_we[i]  = w_wr && (w_dec.sel == MT_REG_CHCTRL) && (w_dec.ch == 3'(i));
      w_clr[i]    = w_wr && (w_dec.sel == MT_REG_STATUS) && wdata_i[i];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    riscv_mtimer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_count   (r_count),
      .i_tick    (w_tick),
      .i_cmp_we  (w_cmp_we[g]),
      .i_ie_we   (w_ie_we[g]),
      .i_clr     (w_clr[g]),
      .i_wdata   (wdata_i),
      .o_match   (w_match[g]),
      .o_pend_ie (w_pend_ie[g]),
      .o_pending (w_pending[g]),
      .o_ie      (w_ie[g]),
      .o_cmp_lo  (w_cmp_lo[g])
    );
  end

  always_comb begin
    w_rd = '0;
    case (w_dec.sel)
      MT_REG_CTRL: begin
        w_rd[MT_CTRL_EN_BIT]     = r_en;
        w_rd[MT_CTRL_RELOAD_BIT] = r_reload;
      end
      MT_REG_PSC:    w_rd = w_psc_rd;
      MT_REG_CNT_LO: w_rd = w_cnt_lo_rd;
      MT_REG_CNT_HI: w_rd = w_cnt_hi_rd;
      MT_REG_STATUS: w_rd = 32'(w_pending);
      MT_REG_CMP: begin
        for (int i = 0; i < N_CH; i++)
          if (w_dec.ch == 3'(i)) w_rd = w_cmp_lo[i];
      end
      MT_REG_CHCTRL: begin
        for (int i = 0; i < N_CH; i++)
          if (w_dec.ch == 3'(i)) w_rd[MT_CHCTRL_IE_BIT] = w_ie[i];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_reload <= 1'b0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_dec.sel == MT_REG_CTRL)) begin
        r_en     <= wdata_i[MT_CTRL_EN_BIT];
        r_reload <= wdata_i[MT_CTRL_RELOAD_BIT];
      end
      r_count <= w_count_nxt;
      r_ack   <= req_i;
      r_rdata <= (req_i && !we_i) ? w_rd : '0;
      r_irq   <= |w_pend_ie;
    end
  end

  assign rdata_o     = r_rdata;
  assign ack_o       = r_ack;
  assign timer_irq_o = r_irq;

endmodule
